// File: rtl/serial_add.sv
// Digit-serial adder: DIGIT bits per cycle, LSB first, one registered carry between digits.
// Optional subtract path (port sub) is built only when SERIAL_ADD_SUB_EN is defined.
module serial_add #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);

  if ((WIDTH < 2) || (DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_cfg
    $error("serial_add: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             carry;
  logic [CW-1:0]    count;
  logic [DIGIT-1:0] dsum;
  logic [DIGIT:0]   c;
  logic             step;
  logic [WIDTH+DIGIT-1:0] sum_cat;

  // Ripple through one digit; only the digit's carry-out is registered.
  always_comb begin
    c[0] = carry;
    for (int i = 0; i < DIGIT; i++) begin
      dsum[i]  = a_sh[i] ^ b_sh[i] ^ c[i];
      c[i+1]   = (a_sh[i] & b_sh[i]) | (b_sh[i] & c[i]) | (a_sh[i] & c[i]);
    end
  end

  assign step    = (state == RUN) && (count != CW'(N));
  assign sum_cat = {dsum, sum};
  assign cout    = carry;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid) state_nxt = RUN;
      end
      // The cycle after the last digit commits the result to DONE.
      RUN:  if (count == CW'(N)) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      sum   <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && in_valid) begin
        a_sh  <= a;
`ifdef SERIAL_ADD_SUB_EN
        b_sh  <= sub ? ~b : b;
        carry <= cin ^ sub;
`else
        b_sh  <= b;
        carry <= cin;
`endif
        count <= '0;
      end else if (step) begin
        a_sh  <= a_sh >> DIGIT;
        b_sh  <= b_sh >> DIGIT;
        sum   <= sum_cat[WIDTH+DIGIT-1:DIGIT];
        carry <= c[DIGIT];
        ovf   <= c[DIGIT] ^ c[DIGIT-1];
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_add.sv
// Directed bench for serial_add: WIDTH=8 with DIGIT=1 and DIGIT=4 instances,
// expected results queued at stimulus time and compared when out_valid rises.
module tb_serial_add;

  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       o;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, sel, in_valid, out_ready;
  logic [7:0] a, b;
  logic       cin, sub;

  logic       iv8, iv4, or8, or4;
  logic       in_ready8, out_valid8, cout8, ovf8;
  logic       in_ready4, out_valid4, cout4, ovf4;
  logic [7:0] sum8, sum4;
  logic       rdy, vld, ocout, oovf;
  logic [7:0] osum;

  assign iv8   = in_valid & ~sel;
  assign iv4   = in_valid & sel;
  assign or8   = out_ready & ~sel;
  assign or4   = out_ready & sel;
  assign rdy   = sel ? in_ready4  : in_ready8;
  assign vld   = sel ? out_valid4 : out_valid8;
  assign osum  = sel ? sum4       : sum8;
  assign ocout = sel ? cout4      : cout8;
  assign oovf  = sel ? ovf4       : ovf8;

  serial_add #(.WIDTH(8), .DIGIT(1)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(in_ready8),
    .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid8), .out_ready(or8),
    .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_add #(.WIDTH(8), .DIGIT(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(in_ready4),
    .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid4), .out_ready(or4),
    .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  res_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain 9-bit add; overflow from operand/result sign bits.
  function automatic res_t model(input logic [7:0] x, input logic [7:0] y,
                                 input logic ci, input logic s);
    logic [7:0] yy;
    logic       cc;
    logic [8:0] r;
    res_t       e;
    yy  = s ? ~y : y;
    cc  = s ? ~ci : ci;
    r   = {1'b0, x} + {1'b0, yy} + {8'd0, cc};
    e.s = r[7:0];
    e.c = r[8];
    e.o = (x[7] == yy[7]) && (r[7] != x[7]);
    return e;
  endfunction

  task automatic xfer(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                      input logic tc, input logic ts, input int hold);
    int         n, t, lat;
    res_t       e;
    logic [9:0] snap;
    logic       frozen;
    n = 0;
    while (!rdy && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_rdy"}, rdy, 1);
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    q.push_back(model(ta, tb, tc, ts));
    @(negedge clk);
    t = cyc;
    in_valid = 1'b0;
    a = ~ta; b = ~tb; cin = ~tc; sub = ~ts;
    n = 0;
    while (!vld && n < 50) begin @(negedge clk); n++; end
    lat = cyc - t;
    chk({tag, "_lat"}, lat, sel ? 3 : 9);
    if (hold > 0) begin
      snap   = {osum, ocout, oovf};
      frozen = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if ({osum, ocout, oovf} !== snap || rdy !== 1'b0 || vld !== 1'b1) frozen = 1'b0;
      end
      chk({tag, "_frozen"}, frozen, 1);
    end
    e = q.pop_front();
    chk({tag, "_sum"}, osum, e.s);
    chk({tag, "_cout"}, ocout, e.c);
    chk({tag, "_ovf"}, oovf, e.o);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle_rdy"}, rdy, 1);
    chk({tag, "_idle_vld"}, vld, 0);
  endtask

  initial begin
    logic [7:0] ra, rb;
    sel = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sum", sum8, 0);
    chk("rst_cout", cout8, 0);
    chk("rst_ovf", ovf8, 0);
    chk("rst_vld", out_valid8, 0);
    chk("rst_rdy8", in_ready8, 0);
    chk("rst_rdy4", in_ready4, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", in_ready8, 1);

    xfer("t1_ff01", 8'hFF, 8'h01, 1'b0, 1'b0, 0);
    xfer("t2_7f01", 8'h7F, 8'h01, 1'b0, 1'b0, 0);
    xfer("t2_8080", 8'h80, 8'h80, 1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      xfer("rnd8", ra, rb, 1'($urandom_range(0, 1)), 1'b0, 0);
    end
    xfer("t4_bp", 8'h3C, 8'h4B, 1'b1, 1'b0, 20);

    sel = 1'b1;
    xfer("t3_d4", 8'hA5, 8'h5A, 1'b1, 1'b0, 0);
    ra = 8'($urandom_range(0, 255));
    rb = 8'($urandom_range(0, 255));
    xfer("rnd4", ra, rb, 1'b0, 1'b0, 0);
    sel = 1'b0;

    // Abort a transaction in its 4th RUN cycle.
    a = 8'h55; b = 8'h33; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    q.push_back(model(8'h55, 8'h33, 1'b1, 1'b0));
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_sum", sum8, 0);
    chk("t5_cout", cout8, 0);
    chk("t5_ovf", ovf8, 0);
    chk("t5_vld", out_valid8, 0);
    chk("t5_rdy_in_rst", in_ready8, 0);
    void'(q.pop_back());
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rdy_after", in_ready8, 1);
    xfer("t5_0304", 8'h03, 8'h04, 1'b0, 1'b0, 0);

`ifdef SERIAL_ADD_SUB_EN
    xfer("t6_sub0507", 8'h05, 8'h07, 1'b0, 1'b1, 0);
    xfer("t6_sub8001", 8'h80, 8'h01, 1'b0, 1'b1, 0);
    sel = 1'b1;
    xfer("t6_sub_d4", 8'h10, 8'h20, 1'b1, 1'b1, 0);
    sel = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
